// File: rtl/global_sequencer.sv
//==============================================================================
// Module      : global_sequencer
// Description : Central program sequencer for a cell array. Fetches 16-bit
//               instructions from an external ROM, broadcasts them to the
//               cells, and resolves jumps, consensus branches, calls and
//               returns against an on-chip 31-entry return-address stack.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module global_sequencer #(
  parameter logic [3:0] OP_JUMP = 4'hC,  // unconditional jump to instr[11:0]
  parameter logic [3:0] OP_UNL  = 4'hD,  // branch to instr[7:0] when all cells diverge
  parameter logic [3:0] OP_CALL = 4'hE,  // push pc+1, jump to instr[11:0]
  parameter logic [3:0] OP_RET  = 4'hF   // pop return address
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [11:0] instr_addr,
  input  logic [15:0] instr_data,
  input  logic        all_diverge,
  output logic [15:0] instruction,
  output logic        execution_enable,
  output logic [11:0] next_program_counter,
  output logic [4:0]  next_stack_pointer,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [4:0]  c_SP_FULL  = 5'd31;
  localparam logic [15:0] c_HALT_INS = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_pc;
  logic [11:0] w_pc_nxt;
  logic [4:0]  r_sp;
  logic [4:0]  w_sp_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        r_error;
  logic        w_error_nxt;
  logic        w_push;
  logic        w_exec_en;

  // Return-address stack; sp always points at the next free slot.
  logic [11:0] r_stack [0:30];

  logic [3:0]  w_opcode;
  logic [11:0] w_pc_inc;
  logic [4:0]  w_sp_dec;
  logic [11:0] w_stack_top;
  logic        w_is_halt;

  assign w_opcode    = instr_data[15:12];
  assign w_pc_inc    = r_pc + 12'd1;          // natural 12-bit wrap at 0xFFF
  assign w_sp_dec    = r_sp - 5'd1;
  assign w_stack_top = r_stack[w_sp_dec];     // only consumed when sp != 0
  assign w_is_halt   = (instr_data == c_HALT_INS);

  // Next-state, next-pc/sp and commit-enable decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_sp_nxt    = r_sp;
    w_done_nxt  = r_done;
    w_error_nxt = r_error;
    w_push      = 1'b0;
    w_exec_en   = 1'b0;

    case (r_state)
      S_IDLE, S_HALT: begin
        // Restart from address 0 with a clean stack and status flags.
        if (start) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = 12'd0;
          w_sp_nxt    = 5'd0;
          w_done_nxt  = 1'b0;
          w_error_nxt = 1'b0;
        end
      end

      S_FETCH: begin
        w_state_nxt = S_EXEC;
      end

      S_EXEC: begin
        w_state_nxt = S_FETCH;
        if (w_is_halt) begin
          w_state_nxt = S_HALT;
          w_done_nxt  = 1'b1;
        end else if (w_opcode == OP_JUMP) begin
          w_pc_nxt = instr_data[11:0];
        end else if (w_opcode == OP_UNL) begin
          // Consensus branch: cells still commit this instruction.
          w_exec_en = 1'b1;
          w_pc_nxt  = all_diverge ? {4'b0000, instr_data[7:0]} : w_pc_inc;
        end else if (w_opcode == OP_CALL) begin
          if (r_sp == c_SP_FULL) begin
            // Overflow: freeze pc/sp so the faulting call stays visible.
            w_state_nxt = S_HALT;
            w_error_nxt = 1'b1;
          end else begin
            w_push   = 1'b1;
            w_sp_nxt = r_sp + 5'd1;
            w_pc_nxt = instr_data[11:0];
          end
        end else if (w_opcode == OP_RET) begin
          if (r_sp == 5'd0) begin
            // Underflow: same freeze behaviour as overflow.
            w_state_nxt = S_HALT;
            w_error_nxt = 1'b1;
          end else begin
            w_sp_nxt = w_sp_dec;
            w_pc_nxt = w_stack_top;
          end
        end else begin
          w_exec_en = 1'b1;
          w_pc_nxt  = w_pc_inc;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, pc, sp and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= 12'd0;
      r_sp    <= 5'd0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_sp    <= w_sp_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
    end
  end

  // Stack write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_stack[r_sp] <= w_pc_inc;
    end
  end

  assign instr_addr           = (r_state == S_FETCH) ? r_pc : 12'd0;
  assign instruction          = (r_state == S_EXEC) ? instr_data : 16'h0000;
  assign execution_enable     = w_exec_en;
  assign next_program_counter = w_pc_nxt;
  assign next_stack_pointer   = w_sp_nxt;
  assign busy                 = (r_state == S_FETCH) || (r_state == S_EXEC);
  assign done                 = r_done;
  assign error                = r_error;

endmodule

`default_nettype wire

// File: tb/tb_global_sequencer.sv
//==============================================================================
// Module      : tb_global_sequencer
// Description : Self-checking bench for global_sequencer with a synchronous
//               ROM model, single-instruction vector table and hand-written
//               multi-cycle sequences.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_global_sequencer;

  localparam logic [3:0] OP_JUMP = 4'hC;
  localparam logic [3:0] OP_UNL  = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hE;
  localparam logic [3:0] OP_RET  = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        all_diverge = 1'b0;
  logic [11:0] instr_addr;
  logic [15:0] instr_data;
  logic [15:0] instruction;
  logic        execution_enable;
  logic [11:0] next_program_counter;
  logic [4:0]  next_stack_pointer;
  logic        busy;
  logic        done;
  logic        error;

  logic [15:0] rom [0:4095];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [11:0] addr;   // where the instruction under test lives
    logic [15:0] instr;
    logic        div;    // all_diverge during its EXEC cycle
    logic [11:0] npc;
    logic [4:0]  nsp;
    logic        ee;
    logic        done;   // status after the EXEC edge
    logic        err;
  } vec_t;

  vec_t vecs [0:8];
  vec_t sb_q [$];

  global_sequencer dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .instr_addr           (instr_addr),
    .instr_data           (instr_data),
    .all_diverge          (all_diverge),
    .instruction          (instruction),
    .execution_enable     (execution_enable),
    .next_program_counter (next_program_counter),
    .next_stack_pointer   (next_stack_pointer),
    .busy                 (busy),
    .done                 (done),
    .error                (error)
  );

  always #5 clk = ~clk;

  // ROM: word is valid the cycle after the address is presented.
  always @(posedge clk) instr_data <= rom[instr_addr];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, 32'(instr_addr), 32'h0);
    check({tag, "_instr"}, 32'(instruction), 32'h0);
    check({tag, "_ee"}, 32'(execution_enable), 32'h0);
    check({tag, "_npc"}, 32'(next_program_counter), 32'h0);
    check({tag, "_nsp"}, 32'(next_stack_pointer), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_err"}, 32'(error), 32'h0);
  endtask

  // Jump from address 0 to the vector's address, then execute it.
  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    clear_rom();
    rom[0]      = {OP_JUMP, v.addr};
    rom[v.addr] = v.instr;
    do_reset();
    sb_q.push_back(v);
    all_diverge = ~v.div;           // must be ignored outside EXEC
    do_start();                     // FETCH @0
    tick();                         // EXEC jump
    tick();                         // FETCH @addr
    sample();
    check($sformatf("v%0d_fetch_addr", idx), 32'(instr_addr), 32'(v.addr));
    tick();                         // EXEC instruction under test
    all_diverge = v.div;
    sample();
    e = sb_q.pop_front();
    check($sformatf("v%0d_instr", idx), 32'(instruction), 32'(e.instr));
    check($sformatf("v%0d_npc", idx), 32'(next_program_counter), 32'(e.npc));
    check($sformatf("v%0d_nsp", idx), 32'(next_stack_pointer), 32'(e.nsp));
    check($sformatf("v%0d_ee", idx), 32'(execution_enable), 32'(e.ee));
    tick();
    all_diverge = 1'b0;
    sample();
    check($sformatf("v%0d_done", idx), 32'(done), 32'(e.done));
    check($sformatf("v%0d_err", idx), 32'(error), 32'(e.err));
    check($sformatf("v%0d_busy", idx), 32'(busy), 32'(!(e.done || e.err)));
  endtask

  initial begin
    //          addr     instr     div   npc      nsp    ee    done  err
    vecs[0] = '{12'h005, 16'hD040, 1'b1, 12'h040, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{12'h005, 16'hD040, 1'b0, 12'h006, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{12'h044, 16'hD0FF, 1'b1, 12'h0FF, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{12'hFFF, 16'h1234, 1'b0, 12'h000, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{12'h050, 16'h5ABC, 1'b1, 12'h051, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{12'h300, 16'hC123, 1'b0, 12'h123, 5'd0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{12'h010, 16'hE200, 1'b0, 12'h200, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{12'h020, 16'hF000, 1'b0, 12'h020, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{12'h007, 16'h0000, 1'b0, 12'h007, 5'd0, 1'b0, 1'b1, 1'b0};

    // Basic run: one ALU op then HALT.
    clear_rom();
    rom[0] = 16'h1234;
    rom[1] = 16'h0000;
    do_reset();
    sample();
    check_zero("reset");
    do_start();
    sample();
    check("b_fetch_addr", 32'(instr_addr), 32'h0);
    check("b_fetch_busy", 32'(busy), 32'h1);
    check("b_fetch_ee", 32'(execution_enable), 32'h0);
    tick();
    sample();
    check("b_exec_ee", 32'(execution_enable), 32'h1);
    check("b_exec_instr", 32'(instruction), 32'h1234);
    check("b_exec_npc", 32'(next_program_counter), 32'h001);
    tick();
    sample();
    check("b_fetch2_ee", 32'(execution_enable), 32'h0);
    check("b_fetch2_addr", 32'(instr_addr), 32'h001);
    tick();
    sample();
    check("b_halt_ee", 32'(execution_enable), 32'h0);
    check("b_halt_done_early", 32'(done), 32'h0);
    tick();
    sample();
    check("b_done", 32'(done), 32'h1);
    check("b_busy", 32'(busy), 32'h0);
    check("b_err", 32'(error), 32'h0);

    // Table of single-instruction vectors.
    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Jump redirects the following fetch.
    clear_rom();
    rom[0]      = 16'hC123;
    rom[12'h123] = 16'h0000;
    do_reset();
    do_start();
    tick();
    sample();
    check("j_npc", 32'(next_program_counter), 32'h123);
    check("j_ee", 32'(execution_enable), 32'h0);
    tick();
    sample();
    check("j_next_addr", 32'(instr_addr), 32'h123);

    // Call then return.
    clear_rom();
    rom[0]       = 16'hC010;
    rom[12'h010] = 16'hE200;
    rom[12'h200] = 16'hF000;
    rom[12'h011] = 16'h0000;
    do_reset();
    do_start();
    tick();                         // EXEC jump
    tick();                         // FETCH 0x010
    tick();                         // EXEC call
    sample();
    check("c_call_nsp", 32'(next_stack_pointer), 32'd1);
    check("c_call_npc", 32'(next_program_counter), 32'h200);
    tick();
    sample();
    check("c_fetch_200", 32'(instr_addr), 32'h200);
    tick();                         // EXEC ret
    sample();
    check("c_ret_npc", 32'(next_program_counter), 32'h011);
    check("c_ret_nsp", 32'(next_stack_pointer), 32'd0);
    tick();
    sample();
    check("c_fetch_011", 32'(instr_addr), 32'h011);

    // Return with empty stack, then restart from HALT.
    clear_rom();
    rom[0] = 16'hF000;
    do_reset();
    do_start();
    tick();
    sample();
    check("u_ee", 32'(execution_enable), 32'h0);
    check("u_npc", 32'(next_program_counter), 32'h000);
    tick();
    sample();
    check("u_err", 32'(error), 32'h1);
    check("u_done", 32'(done), 32'h0);
    check("u_busy", 32'(busy), 32'h0);
    do_start();
    sample();
    check("u_restart_busy", 32'(busy), 32'h1);
    check("u_restart_err", 32'(error), 32'h0);

    // 31 nested calls fill the stack; the 32nd overflows.
    clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = {OP_CALL, 12'(i + 1)};
    do_reset();
    do_start();
    for (int n = 0; n < 31; n++) begin
      tick();
      sample();
      check($sformatf("o_nsp_%0d", n), 32'(next_stack_pointer), 32'(n + 1));
      tick();
    end
    tick();
    sample();
    check("o_full_nsp", 32'(next_stack_pointer), 32'd31);
    check("o_full_npc", 32'(next_program_counter), 32'h01F);
    tick();
    sample();
    check("o_err", 32'(error), 32'h1);
    check("o_done", 32'(done), 32'h0);
    check("o_busy", 32'(busy), 32'h0);

    // Reset in the middle of EXEC.
    clear_rom();
    rom[0] = 16'h1234;
    do_reset();
    do_start();
    tick();
    sample();
    check("r_exec_ee", 32'(execution_enable), 32'h1);
    rst = 1'b1;
    start = 1'b1;                   // reset wins over start
    tick();
    rst = 1'b0;
    start = 1'b0;
    sample();
    check_zero("midrst");
    tick();
    sample();
    check("r_idle_busy", 32'(busy), 32'h0);
    do_start();
    sample();
    check("r_idle_start", 32'(busy), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/global_sequencer.md
GLOBAL_SEQUENCER -- requirements
Module: global_sequencer

Interface
REQ-001 The block SHALL have parameter OP_JUMP, default 4'hC, meaning the unconditional jump opcode (target address is instruction[11:0]).
REQ-002 The block SHALL have parameter OP_UNL, default 4'hD, meaning the consensus conditional branch opcode (target address is {4'b0, instruction[7:0]}).
REQ-003 The block SHALL have parameter OP_CALL, default 4'hE, meaning call to instruction[11:0] with return-address push.
REQ-004 The block SHALL have parameter OP_RET, default 4'hF, meaning return via stack pop, with OP_HALT fixed at instruction == 16'h0000.
REQ-005 The block SHALL have the port clk  input  1  clock.
REQ-006 The block SHALL have the port rst  input  1  reset, synchronous, active-high.
REQ-007 The block SHALL have the port start  input  1  begins execution at address 0 from IDLE or HALT.
REQ-008 The block SHALL have the port instr_addr  output  12  instruction ROM address.
REQ-009 The block SHALL have the port instr_data  input  16  ROM word, valid the cycle after instr_addr is presented.
REQ-010 The block SHALL have the port all_diverge  input  1  AND-reduction of every cell's diverge.
REQ-011 The block SHALL have the port instruction  output  16  broadcast instruction; instr_data in EXEC, 0 otherwise.
REQ-012 The block SHALL have the port execution_enable  output  1  cells may commit this cycle.
REQ-013 The block SHALL have the port next_program_counter  output  12  PC after the current cycle.
REQ-014 The block SHALL have the port next_stack_pointer  output  5  SP after the current cycle.
REQ-015 The block SHALL have the port busy  output  1  state is FETCH or EXEC.
REQ-016 The block SHALL have the port done  output  1  HALT reached normally (level).
REQ-017 The block SHALL have the port error  output  1  stack overflow or underflow (level).

Function
REQ-018 The block SHALL implement the states IDLE, FETCH, EXEC, HALT.
REQ-019 IDLE SHALL go to FETCH on start=1 with pc=0, sp=0, done=0, error=0; HALT SHALL do the same on start=1; start SHALL be ignored in FETCH and EXEC.
REQ-020 FETCH SHALL drive instr_addr=pc and go to EXEC next cycle; every instruction SHALL take exactly 2 cycles.
REQ-021 In EXEC, execution_enable SHALL be 1 except for OP_JUMP, OP_CALL, OP_RET and HALT; in all other states it SHALL be 0.
REQ-022 When not in EXEC, next_program_counter SHALL equal pc and next_stack_pointer SHALL equal sp.
REQ-023 In EXEC, OP_JUMP SHALL set next pc = instruction[11:0].
REQ-024 In EXEC, OP_UNL SHALL set next pc = {4'b0, instruction[7:0]} if all_diverge=1, otherwise pc+1.
REQ-025 In EXEC, OP_CALL SHALL write pc+1 to stack[sp], set sp+1 and set next pc = instruction[11:0].
REQ-026 In EXEC, OP_RET SHALL set sp-1 and next pc = stack[sp-1].
REQ-027 In EXEC, any other non-HALT opcode SHALL set next pc = pc+1, modulo 4096 (0xFFF wraps to 0x000).
REQ-028 The stack SHALL be 31 entries x 12 bits, with sp as the next-free index.
REQ-029 OP_CALL with sp==31 SHALL set error=1 and enter HALT with pc and sp unchanged, and no push.
REQ-030 OP_RET with sp==0 SHALL set error=1 and enter HALT with pc and sp unchanged.
REQ-031 On an error, done SHALL remain 0.
REQ-032 HALT (instruction 16'h0000) in EXEC SHALL set done=1, enter HALT and hold pc.
REQ-033 next_program_counter and next_stack_pointer SHALL be combinational from state, instr_data and all_diverge, and SHALL equal the pc/sp registered at the following edge.
REQ-034 A non-EXEC all_diverge value SHALL be ignored.

Reset
REQ-035 On rst=1 at a clock edge, the block SHALL set state=IDLE, pc=0, sp=0, done=0, error=0, and all outputs SHALL be 0, including from mid-instruction.
REQ-036 Stack contents SHALL NOT be cleared by reset.
REQ-037 rst SHALL take priority over start.

Verification
REQ-038 The bench SHALL cover: ROM 0:16'h1234, 1:16'h0000; reset, start -> instr_addr 0, then execution_enable=1 for exactly one cycle with instruction=16'h1234, then done=1 four cycles after start, busy=0, error=0.
REQ-039 The bench SHALL cover: ROM 0:OP_JUMP 0x123 -> in EXEC next_program_counter=0x123 and execution_enable=0, then the next instr_addr=0x123.
REQ-040 The bench SHALL cover: ROM 5:OP_UNL imm 0x40 -> with all_diverge=1, next_program_counter=0x040; with all_diverge=0, next_program_counter=0x006.
REQ-041 The bench SHALL cover: ROM 0x010:OP_CALL 0x200 and 0x200:OP_RET -> next_stack_pointer=1 and pc 0x200, then pc 0x011 and next_stack_pointer=0.
REQ-042 The bench SHALL cover: OP_RET at sp=0 -> error=1, state HALT, done=0; 31 nested calls then one more OP_CALL -> error=1 with sp=31.
REQ-043 The bench SHALL cover: pc 0xFFF holding a non-branch -> next_program_counter=0x000; and rst asserted during EXEC -> all outputs 0 at the next cycle and state IDLE.
